// File: rtl/rv_decode_stage.sv
// ---------------------------------------------------------------------------
// rv_decode_stage
//
// Registered instruction-decode stage for the Lab3 RV32 CPU. Accepts one
// 32-bit instruction per cycle (valid/ready) and presents the decoded fields
// one cycle later on a second valid/ready handshake. Decodes R-type (with
// optional M-extension multiplies), I-type ALU, LUI and CSRRW; anything else
// is flagged illegal.
//
// Optional feature macro: RV_DECODE_MUL_EN
//   defined   -> MUL / MULH / MULHU decode (alu_op 10..12)
//   undefined -> funct7 0000001 under the R-type opcode is illegal
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   instr_valid    upstream has an instruction in instr
//   instr[31:0]    raw instruction word
//   instr_ready    stage accepts instr this cycle (!dec_valid || dec_ready)
//   dec_valid      decoded fields valid
//   dec_ready      downstream consumes decoded fields
//   rs1/rs2/rd     register indices
//   alu_op[3:0]    ALU operation (15 = NOP)
//   imm[31:0]      decoded immediate
//   use_imm        ALU B operand is imm instead of rs2
//   reg_we         instruction writes rd (never for rd = x0)
//   csr_addr[11:0] CSR address for CSRRW, else 0
//   illegal        instruction did not decode
//   dec_count      accepted-instruction counter (wraps)
//   illegal_count  accepted-illegal counter (saturates at all-ones)
// ---------------------------------------------------------------------------
module rv_decode_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [3:0]       alu_op,
    output logic [31:0]      imm,
    output logic             use_imm,
    output logic             reg_we,
    output logic [11:0]      csr_addr,
    output logic             illegal,
    output logic [CNT_W-1:0] dec_count,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_SYS   = 7'b1110011;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
`ifdef RV_DECODE_MUL_EN
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULH  = 4'd11;
    localparam logic [3:0] OP_MULHU = 4'd12;
`endif
    localparam logic [3:0] OP_PASSB = 4'd13;
    localparam logic [3:0] OP_CSRRW = 4'd14;
    localparam logic [3:0] OP_NOP   = 4'd15;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULD = 7'b0000001;

    // ------------------------------------------------------------------
    // Field slices
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // ------------------------------------------------------------------
    // Combinational decode. Everything defaults to the illegal result so
    // only the legal paths need to set fields.
    // ------------------------------------------------------------------
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic [3:0]  alu_op_d;
    logic [31:0] imm_d;
    logic        use_imm_d;
    logic        reg_we_d;
    logic [11:0] csr_addr_d;
    logic        legal_d;

    always_comb begin
        rs1_d      = instr[19:15];
        rs2_d      = instr[24:20];
        rd_d       = instr[11:7];
        alu_op_d   = OP_NOP;
        imm_d      = 32'd0;
        use_imm_d  = 1'b0;
        csr_addr_d = 12'd0;
        legal_d    = 1'b0;

        case (opcode)
            OPC_RTYPE: begin
                case (funct7)
                    F7_BASE: begin
                        legal_d = 1'b1;
                        case (funct3)
                            3'b000:  alu_op_d = OP_ADD;
                            3'b001:  alu_op_d = OP_SLL;
                            3'b010:  alu_op_d = OP_SLT;
                            3'b011:  alu_op_d = OP_SLTU;
                            3'b100:  alu_op_d = OP_XOR;
                            3'b101:  alu_op_d = OP_SRL;
                            3'b110:  alu_op_d = OP_OR;
                            default: alu_op_d = OP_AND;
                        endcase
                    end
                    F7_ALT: begin
                        if (funct3 == 3'b000) begin
                            legal_d  = 1'b1;
                            alu_op_d = OP_SUB;
                        end else if (funct3 == 3'b101) begin
                            legal_d  = 1'b1;
                            alu_op_d = OP_SRA;
                        end
                    end
                    F7_MULD: begin
`ifdef RV_DECODE_MUL_EN
                        case (funct3)
                            3'b000: begin
                                legal_d  = 1'b1;
                                alu_op_d = OP_MUL;
                            end
                            3'b001: begin
                                legal_d  = 1'b1;
                                alu_op_d = OP_MULH;
                            end
                            3'b011: begin
                                legal_d  = 1'b1;
                                alu_op_d = OP_MULHU;
                            end
                            default: ;
                        endcase
`endif
                    end
                    default: ;
                endcase
            end

            OPC_ITYPE: begin
                case (funct3)
                    3'b001: begin
                        if (funct7 == F7_BASE) begin
                            legal_d   = 1'b1;
                            alu_op_d  = OP_SLL;
                            imm_d     = {27'd0, instr[24:20]};
                            use_imm_d = 1'b1;
                        end
                    end
                    3'b101: begin
                        // funct7 selects logical vs arithmetic right shift
                        if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                            legal_d   = 1'b1;
                            alu_op_d  = (funct7 == F7_ALT) ? OP_SRA : OP_SRL;
                            imm_d     = {27'd0, instr[24:20]};
                            use_imm_d = 1'b1;
                        end
                    end
                    default: begin
                        legal_d   = 1'b1;
                        imm_d     = {{20{instr[31]}}, instr[31:20]};
                        use_imm_d = 1'b1;
                        case (funct3)
                            3'b000:  alu_op_d = OP_ADD;
                            3'b010:  alu_op_d = OP_SLT;
                            3'b011:  alu_op_d = OP_SLTU;
                            3'b100:  alu_op_d = OP_XOR;
                            3'b110:  alu_op_d = OP_OR;
                            default: alu_op_d = OP_AND;
                        endcase
                    end
                endcase
            end

            OPC_LUI: begin
                legal_d   = 1'b1;
                alu_op_d  = OP_PASSB;
                imm_d     = {instr[31:12], 12'd0};
                use_imm_d = 1'b1;
                rs1_d     = 5'd0;
                rs2_d     = 5'd0;
            end

            OPC_SYS: begin
                if (funct3 == 3'b001) begin
                    legal_d    = 1'b1;
                    alu_op_d   = OP_CSRRW;
                    csr_addr_d = instr[31:20];
                end
            end

            default: ;
        endcase

        reg_we_d = legal_d && (rd_d != 5'd0);
    end

    // ------------------------------------------------------------------
    // Handshake and output registers
    // ------------------------------------------------------------------
    logic             dec_valid_q;
    logic [4:0]       rs1_q, rs2_q, rd_q;
    logic [3:0]       alu_op_q;
    logic [31:0]      imm_q;
    logic             use_imm_q;
    logic             reg_we_q;
    logic [11:0]      csr_addr_q;
    logic             illegal_q;
    logic [CNT_W-1:0] dec_count_q;
    logic [CNT_W-1:0] illegal_count_q;
    logic             accept;

    assign instr_ready = !dec_valid_q || dec_ready;
    assign accept      = instr_valid && instr_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dec_valid_q     <= 1'b0;
            rs1_q           <= 5'd0;
            rs2_q           <= 5'd0;
            rd_q            <= 5'd0;
            alu_op_q        <= OP_NOP;
            imm_q           <= 32'd0;
            use_imm_q       <= 1'b0;
            reg_we_q        <= 1'b0;
            csr_addr_q      <= 12'd0;
            illegal_q       <= 1'b0;
            dec_count_q     <= '0;
            illegal_count_q <= '0;
        end else begin
            if (accept) begin
                dec_valid_q <= 1'b1;
                rs1_q       <= rs1_d;
                rs2_q       <= rs2_d;
                rd_q        <= rd_d;
                alu_op_q    <= alu_op_d;
                imm_q       <= imm_d;
                use_imm_q   <= use_imm_d;
                reg_we_q    <= reg_we_d;
                csr_addr_q  <= csr_addr_d;
                illegal_q   <= !legal_d;
                dec_count_q <= dec_count_q + 1'b1;
                if (!legal_d && (illegal_count_q != '1)) begin
                    illegal_count_q <= illegal_count_q + 1'b1;
                end
            end else if (dec_ready) begin
                dec_valid_q <= 1'b0;
            end
        end
    end

    assign dec_valid     = dec_valid_q;
    assign rs1           = rs1_q;
    assign rs2           = rs2_q;
    assign rd            = rd_q;
    assign alu_op        = alu_op_q;
    assign imm           = imm_q;
    assign use_imm       = use_imm_q;
    assign reg_we        = reg_we_q;
    assign csr_addr      = csr_addr_q;
    assign illegal       = illegal_q;
    assign dec_count     = dec_count_q;
    assign illegal_count = illegal_count_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
module tb_rv_decode_stage;

    localparam int CNT_W = 4;   // small so wrap and saturation are reachable

    logic             clk = 1'b0;
    logic             rst;
    logic             instr_valid;
    logic [31:0]      instr;
    logic             instr_ready;
    logic             dec_valid;
    logic             dec_ready;
    logic [4:0]       rs1, rs2, rd;
    logic [3:0]       alu_op;
    logic [31:0]      imm;
    logic             use_imm;
    logic             reg_we;
    logic [11:0]      csr_addr;
    logic             illegal;
    logic [CNT_W-1:0] dec_count;
    logic [CNT_W-1:0] illegal_count;

    rv_decode_stage #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .rs1           (rs1),
        .rs2           (rs2),
        .rd            (rd),
        .alu_op        (alu_op),
        .imm           (imm),
        .use_imm       (use_imm),
        .reg_we        (reg_we),
        .csr_addr      (csr_addr),
        .illegal       (illegal),
        .dec_count     (dec_count),
        .illegal_count (illegal_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      word;
        logic [4:0]       rs1, rs2, rd;
        logic [3:0]       alu_op;
        logic [31:0]      imm;
        logic             use_imm, reg_we, illegal;
        logic [11:0]      csr;
        logic [CNT_W-1:0] dc, ic;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] m_dcnt = '0;
    logic [CNT_W-1:0] m_icnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h @%0t", name, act, req, $time);
        end
    endtask

    // Reference decoder: computes the architectural result of one word.
    function automatic exp_t model(input logic [31:0] w);
        exp_t       e;
        logic [3:0] r_ops [8];
        logic [3:0] i_ops [8];
        logic [6:0] opc = w[6:0];
        logic [2:0] f3  = w[14:12];
        logic [6:0] f7  = w[31:25];
        bit         mul_en = 1'b0;
`ifdef RV_DECODE_MUL_EN
        mul_en = 1'b1;
`endif
        // funct3 -> op, base R-type and I-type ALU
        r_ops = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        i_ops = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        e = '0;
        e.word = w;
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.rd  = w[11:7];
        e.alu_op = 4'd15;
        e.illegal = 1'b1;
        if (opc == 7'h33) begin
            if (f7 == 7'h00) begin
                e.alu_op = r_ops[f3]; e.illegal = 0;
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
                e.alu_op = 4'd1; e.illegal = 0;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
                e.alu_op = 4'd7; e.illegal = 0;
            end else if (f7 == 7'h01 && mul_en && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd3)) begin
                e.alu_op = (f3 == 3'd3) ? 4'd12 : 4'd10 + 4'(f3); e.illegal = 0;
            end
        end else if (opc == 7'h13) begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
                if (f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20)) begin
                    e.alu_op = (f3 == 3'd1) ? 4'd5 : (f7 == 7'h20 ? 4'd7 : 4'd6);
                    e.imm = 32'(w[24:20]);
                    e.use_imm = 1; e.illegal = 0;
                end
            end else begin
                e.alu_op = i_ops[f3];
                e.imm = 32'($signed(w[31:20]));
                e.use_imm = 1; e.illegal = 0;
            end
        end else if (opc == 7'h37) begin
            e.alu_op = 4'd13; e.imm = {w[31:12], 12'h000};
            e.use_imm = 1; e.illegal = 0; e.rs1 = 0; e.rs2 = 0;
        end else if (opc == 7'h73 && f3 == 3'd1) begin
            e.alu_op = 4'd14; e.csr = w[31:20]; e.illegal = 0;
        end
        e.reg_we = !e.illegal && (e.rd != 5'd0);
        return e;
    endfunction

    // Monitor / scoreboard: samples on the falling edge.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            exp_t e;
            chk("dec_valid", 32'(dec_valid), 32'(sb.size() != 0));
            chk("instr_ready", 32'(instr_ready), 32'((sb.size() == 0) || dec_ready));
            if (sb.size() > 1) begin
                errors++;
                $display("FAIL sb_depth actual=%0d required<=1", sb.size());
            end
            if (sb.size() != 0 && dec_valid) begin
                e = sb[0];
                chk("rs1", 32'(rs1), 32'(e.rs1));
                chk("rs2", 32'(rs2), 32'(e.rs2));
                chk("rd", 32'(rd), 32'(e.rd));
                chk("alu_op", 32'(alu_op), 32'(e.alu_op));
                chk("imm", imm, e.imm);
                chk("use_imm", 32'(use_imm), 32'(e.use_imm));
                chk("reg_we", 32'(reg_we), 32'(e.reg_we));
                chk("csr_addr", 32'(csr_addr), 32'(e.csr));
                chk("illegal", 32'(illegal), 32'(e.illegal));
                chk("dec_count", 32'(dec_count), 32'(e.dc));
                chk("illegal_count", 32'(illegal_count), 32'(e.ic));
                if (dec_ready) begin
                    $display("OUT  instr=0x%08h alu_op=%0d imm=0x%08h ill=%0d dc=%0d ic=%0d",
                             e.word, alu_op, imm, illegal, dec_count, illegal_count);
                    void'(sb.pop_front());
                end
            end
            if (instr_valid && instr_ready) begin
                e = model(instr);
                m_dcnt = m_dcnt + 1'b1;
                if (e.illegal && m_icnt != '1) m_icnt = m_icnt + 1'b1;
                e.dc = m_dcnt;
                e.ic = m_icnt;
                sb.push_back(e);
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] w, input logic r);
        @(posedge clk);
        #1;
        instr_valid = v;
        instr       = w;
        dec_ready   = r;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs [5];
        logic [6:0] f7s  [4];
        logic [31:0] w;
        opcs = '{7'h33, 7'h13, 7'h37, 7'h73, 7'h00};
        f7s  = '{7'h00, 7'h20, 7'h01, 7'h00};
        w = $urandom;
        w[6:0] = opcs[$urandom_range(0, 4)];
        if (w[6:0] == 7'h00) w[6:0] = 7'($urandom);
        if ($urandom_range(0, 3) != 0) w[31:25] = f7s[$urandom_range(0, 3)];
        if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; instr_valid = 1'b0; instr = 32'd0; dec_ready = 1'b1;
        repeat (2) @(negedge clk);
        // reset state
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_instr_ready", 32'(instr_ready), 32'd1);
        chk("rst_alu_op", 32'(alu_op), 32'd15);
        chk("rst_imm", imm, 32'd0);
        chk("rst_fields", {rs1, rs2, rd, use_imm, reg_we, illegal, csr_addr}, 32'd0);
        chk("rst_dec_count", 32'(dec_count), 32'd0);
        chk("rst_illegal_count", 32'(illegal_count), 32'd0);
        #2 rst = 1'b1;

        // ADD, then back-to-back SUB / ADDI / SRAI / LUI
        drive(1, 32'h002081B3, 1);
        drive(1, 32'h402081B3, 1);
        drive(1, 32'hFFF00293, 1);
        drive(1, 32'h40325213, 1);
        drive(1, 32'h123453B7, 1);
        drive(0, 32'd0, 1);
        drive(0, 32'd0, 1);

        // backpressure: ADD held while SUB waits
        drive(1, 32'h002081B3, 1);
        repeat (3) drive(1, 32'h402081B3, 0);
        drive(1, 32'h402081B3, 1);
        drive(0, 32'd0, 1);

        // illegal word, rd = x0 write suppression, multiply
        drive(1, 32'hFFFFFFFF, 1);
        drive(1, 32'h00000013, 1);
        drive(1, 32'h022081B3, 1);
        drive(1, 32'h0000B0F3, 1);   // CSRRW-like with funct3 011: illegal
        drive(1, 32'hABC090F3, 1);   // CSRRW x1, 0xABC, x1
        drive(0, 32'd0, 1);

        // randomized traffic with random backpressure
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) < 7);
        end
        drive(0, 32'd0, 1);
        drive(0, 32'd0, 1);

        // asynchronous reset while an output is pending
        drive(1, 32'h002081B3, 1);
        drive(0, 32'd0, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_dec_valid", 32'(dec_valid), 32'd0);
        chk("async_dec_count", 32'(dec_count), 32'd0);
        chk("async_illegal_count", 32'(illegal_count), 32'd0);
        chk("async_alu_op", 32'(alu_op), 32'd15);
        sb.delete();
        m_dcnt = '0;
        m_icnt = '0;
        instr_valid = 1'b0;
        dec_ready = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;

        drive(1, 32'h00500093, 1);   // ADDI x1, x0, 5
        drive(1, 32'hFFFFFFFF, 1);
        drive(0, 32'd0, 1);
        drive(0, 32'd0, 1);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
